// File: rtl/fir_frame_collector.sv
// Ping-pong frame packer: collects FIR output samples into FRAME_LEN-sample frames
// and offers each complete frame in parallel under a valid/ready handshake.
module fir_frame_collector #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           fir_d,
    input  logic                        fir_valid,
    output logic [DATA_W*FRAME_LEN-1:0] frame_data,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [CNT_W-1:0]            frame_cnt,
    output logic                        overflow,
    output logic [3:0]                  dbg_bank_state
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

    logic accept;
    logic wr_full;
    logic writable;
    logic wr_en;
    logic wr_last;

    // Handshake: a frame transfers on any rising edge where frame_valid and
    // frame_ready are both high; frame_data holds steady until then.
    assign accept   = valid_q & frame_ready;
    assign wr_full  = (bank_q[wr_bank_q] == BANK_FULL);
    // A full write bank can still take a sample if it is being drained this cycle.
    assign writable = !wr_full || (accept && (rd_bank_q == wr_bank_q));
    assign wr_en    = fir_valid & writable;
    assign wr_last  = (wr_idx_q == LAST_IDX);

    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;

        if (accept) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
            cnt_d             = cnt_q + CNT_W'(1);
        end

        if (wr_en) begin
            if (wr_last) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_idx_d          = wr_idx_q + IDX_W'(1);
            end
        end else if (fir_valid) begin
            ovf_d = 1'b1;
        end

        valid_d = (bank_d[rd_bank_d] == BANK_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < FRAME_LEN; k++) begin
                    mem_q[b][k] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_bank_q][wr_idx_q] <= fir_d;
        end
    end

    always_comb begin
        frame_data = '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            frame_data[k*DATA_W +: DATA_W] = mem_q[rd_bank_q][k];
        end
    end

    assign frame_valid    = valid_q;
    assign frame_cnt      = cnt_q;
    assign overflow       = ovf_q;
    assign dbg_bank_state = {bank_q[1], bank_q[0]};

endmodule

// File: tb/tb_fir_frame_collector.sv
// Randomized bench for fir_frame_collector against a queue-based frame model.
module tb_fir_frame_collector;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = 10;
    localparam int FW        = DATA_W * FRAME_LEN;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] fir_d;
    logic              fir_valid;
    logic [FW-1:0]     frame_data;
    logic              frame_valid;
    logic              frame_ready;
    logic [CNT_W-1:0]  frame_cnt;
    logic              overflow;
    logic [3:0]        dbg_bank_state;

    fir_frame_collector #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .fir_d(fir_d), .fir_valid(fir_valid),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .frame_cnt(frame_cnt),
        .overflow(overflow), .dbg_bank_state(dbg_bank_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: complete frames waiting for the consumer, and the frame in progress
    logic [FW-1:0]     exp_q[$];
    logic [DATA_W-1:0] part_q[$];
    int                cnt_m;
    bit                ovf_m;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        part_q.delete();
        cnt_m = 0;
        ovf_m = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit r);
        bit acc;
        bit wr_ok;
        logic [FW-1:0] f;
        acc   = (exp_q.size() > 0) && r;
        wr_ok = (part_q.size() > 0) || ((exp_q.size() - int'(acc)) < 2);
        if (acc) begin
            void'(exp_q.pop_front());
            cnt_m++;
        end
        if (v) begin
            if (wr_ok) begin
                part_q.push_back(d);
                if (part_q.size() == FRAME_LEN) begin
                    f = '0;
                    for (int k = 0; k < FRAME_LEN; k++) f[k*DATA_W +: DATA_W] = part_q[k];
                    exp_q.push_back(f);
                    part_q.delete();
                end
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("valid", FW'(frame_valid), FW'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("data", frame_data, exp_q[0]);
        check("cnt", FW'(frame_cnt), FW'(cnt_m % (1 << CNT_W)));
        check("ovf", FW'(overflow), FW'(ovf_m));
    endtask

    // driver: inputs change at the falling edge, outputs are checked at the next one
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
        fir_valid   = v;
        fir_d       = d;
        frame_ready = r;
        @(posedge clk);
        model_step(v, d, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        fir_valid = 1'b0;
        fir_d     = '0;
        frame_ready = 1'b0;
        model_clear();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_valid", FW'(frame_valid), '0);
        check("rst_data", frame_data, '0);
        check("rst_cnt", FW'(frame_cnt), '0);
        check("rst_ovf", FW'(overflow), '0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int sent;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        fir_valid = 1'b0;
        fir_d = '0;
        frame_ready = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset(2);

        // single frame 1..16 with the consumer always ready
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DATA_W'(i), 1'b1);
            if (i == 15) check("t1_valid_early", FW'(frame_valid), '0);
        end
        check("t1_valid", FW'(frame_valid), FW'(1));
        lo = frame_data[DATA_W-1:0];
        hi = frame_data[FW-1 -: DATA_W];
        check("t1_lo", FW'(lo), FW'(1));
        check("t1_hi", FW'(hi), FW'(16));
        step(1'b0, '0, 1'b1);
        check("t1_cnt", FW'(frame_cnt), FW'(1));
        check("t1_ovf", FW'(overflow), '0);

        // stalled consumer: third frame dropped
        do_reset(1);
        for (int i = 0; i < 48; i++) step(1'b1, DATA_W'(i), 1'b0);
        check("t2_ovf", FW'(overflow), FW'(1));
        lo = frame_data[DATA_W-1:0];
        check("t2_first", FW'(lo), FW'(0));
        step(1'b0, '0, 1'b1);
        lo = frame_data[DATA_W-1:0];
        check("t2_second", FW'(lo), FW'(16));
        step(1'b0, '0, 1'b1);
        check("t2_cnt", FW'(frame_cnt), FW'(2));
        check("t2_valid_off", FW'(frame_valid), '0);

        // 64 ramp frames with random input gaps
        do_reset(1);
        sent = 0;
        while (sent < 64 * FRAME_LEN) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, DATA_W'(sent), 1'b1);
                sent++;
            end else begin
                step(1'b0, DATA_W'($urandom), 1'b1);
            end
        end
        repeat (3) step(1'b0, '0, 1'b1);
        check("t3_cnt", FW'(frame_cnt), FW'(64));
        check("t3_ovf", FW'(overflow), '0);

        // both banks full, ready arrives together with the next frame's first sample
        do_reset(1);
        for (int i = 0; i < 32; i++) step(1'b1, DATA_W'(i), 1'b0);
        step(1'b1, DATA_W'(100), 1'b1);
        for (int i = 1; i < 16; i++) step(1'b1, DATA_W'(100 + i), 1'b0);
        check("t4_ovf", FW'(overflow), '0);
        step(1'b0, '0, 1'b1);
        lo = frame_data[DATA_W-1:0];
        check("t4_refill", FW'(lo), FW'(100));

        // reset mid-frame
        do_reset(1);
        for (int i = 0; i < 7; i++) step(1'b1, DATA_W'(500 + i), 1'b0);
        do_reset(2);
        for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(200 + i), 1'b0);
        lo = frame_data[DATA_W-1:0];
        hi = frame_data[FW-1 -: DATA_W];
        check("t5_lo", FW'(lo), FW'(200));
        check("t5_hi", FW'(hi), FW'(215));

        // toggling ready under continuous random input
        do_reset(1);
        for (int i = 0; i < 200; i++) step(1'b1, DATA_W'($urandom), 1'(i % 2));

        // fully random traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom_range(0, 2) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
